// File: rtl/apb_mem_slave_pkg.sv
// Shared APB definitions: bus widths common with the bridge and the slave state encoding.
package apb_mem_slave_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB slave-side bus bundle: the bridge drives the master modport, each slave takes the slave modport.
interface apb_mem_slave_if;
    import apb_mem_slave_pkg::*;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_mem_slave_wait_counter.sv
// Loadable down-counter that paces the access-phase wait states; loads WAIT_CYCLES-1.
module apb_wait_counter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/apb_mem_slave.sv
// APB register-memory slave with programmable wait states and out-of-range error response.
module apb_mem_slave
    import apb_mem_slave_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH       = 24
) (
    input  logic                 pclk,
    input  logic                 Reset,
    apb_mem_slave_if.slave       bus
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write, w_write;
    logic                r_err, w_err;
    logic                r_pready, r_pslverr;
    logic [DATA_W-1:0]   r_prdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_setup, w_cnt_load, w_cnt_en, w_cnt_zero, w_commit;

    apb_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_counter (
        .clk    (pclk),
        .rst    (Reset),
        .i_load (w_cnt_load),
        .i_en   (w_cnt_en),
        .o_zero (w_cnt_zero)
    );

    assign w_setup = bus.psel && !bus.penable;

    // With zero wait states DONE is entered straight from IDLE, so use the live bus there.
    assign w_addr   = (r_state == ST_IDLE) ? bus.paddr : r_addr;
    assign w_write  = (r_state == ST_IDLE) ? bus.pwrite : r_write;
    assign w_err    = (r_state == ST_IDLE) ? ({1'b0, bus.paddr} >= DEPTH_L) : r_err;
    assign w_commit = (r_state == ST_DONE) && r_write && !r_err && bus.psel && bus.penable;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_cnt_load = (WAIT_CYCLES != 0);
                    w_next     = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.psel) begin
                    w_next = ST_IDLE;
                end else if (w_cnt_zero) begin
                    w_next = ST_DONE;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && w_setup) begin
                r_addr  <= bus.paddr;
                r_wdata <= bus.pwdata;
                r_write <= bus.pwrite;
                r_err   <= ({1'b0, bus.paddr} >= DEPTH_L);
            end
            if (w_next == ST_DONE) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_err;
                r_prdata  <= (!w_write && !w_err) ? r_mem[w_addr] : '0;
            end else begin
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
                r_prdata  <= '0;
            end
        end
    end

    // NOTE: the memory is cleared by reset, so it needs a per-word reset loop rather than a RAM macro.
    always_ff @(posedge pclk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign bus.pready  = r_pready;
    assign bus.prdata  = r_prdata;
    assign bus.pslverr = r_pslverr;

endmodule
